// File: rtl/ioctl_load_ctrl.sv
// ioctl_load_ctrl
//   Steers the HPS ioctl download stream into the arcade core:
//   - index 0 bytes go to the ROM write port via a mem_req/mem_ack handshake,
//     with ioctl_wait stalling HPS while a write is outstanding;
//   - DIP_INDEX bytes fill the 64-bit DIP bank, MOD_INDEX bytes the variant flag;
//   - game_reset is held through the download and HOLD_CYCLES afterwards, then
//     follows soft_reset.
//   Optional feature (macro LOAD_CHECKSUM_EN): adds rom_sum[15:0], a wrap-around
//   sum of every acknowledged ROM byte. The default build has no rom_sum port.
//
// Ports:
//   clk_sys, reset_n (synchronous, active-low), soft_reset (active-high)
//   ioctl_download/index/wr/addr/dout : HPS download stream in
//   ioctl_wait                        : back-pressure to HPS
//   mem_req/mem_addr/mem_data/mem_ack : ROM write port (level req, 1-cycle ack)
//   dip_sw[63:0], mod_flag            : configuration outputs
//   game_reset, rom_loaded, ovf_err   : core reset, load status, sticky overrun
//   rom_sum[15:0]                     : only with LOAD_CHECKSUM_EN
module ioctl_load_ctrl #(
  parameter int ADDR_W      = 17,
  parameter int ROM_BYTES   = 98304,
  parameter int HOLD_CYCLES = 1024,
  parameter int DIP_INDEX   = 254,
  parameter int MOD_INDEX   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              soft_reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic [63:0]       dip_sw,
  output logic              mod_flag,
  output logic              game_reset,
  output logic              rom_loaded,
  output logic              ovf_err
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [15:0]       rom_sum
`endif
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nx;
  logic [CNT_W-1:0]   hold_cnt_r;

  logic rom_start_s;
  logic rom_wr_s;
  logic req_nx_s;
  logic reset_nx_s;
  logic latch_s;
  logic hold_load_s;
  logic loaded_set_s;
  logic ack_take_s;
  logic ovf_set_s;
  logic sum_clr_s;

  // A new ROM session starts whenever HPS downloads index 0.
  assign rom_start_s = ioctl_download & (ioctl_index == 8'd0);
  // Only index-0 bytes inside the ROM window produce a write request.
  assign rom_wr_s    = ioctl_wr & (ioctl_index == 8'd0) & (ioctl_addr < 25'(ROM_BYTES));

  // State register and post-download hold counter.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= CNT_W'(0);
    end else begin
      state_r <= state_nx;
      if (hold_load_s) begin
        hold_cnt_r <= CNT_W'(HOLD_CYCLES - 1);
      end else if ((state_r == ST_HOLD) && (hold_cnt_r != CNT_W'(0))) begin
        hold_cnt_r <= hold_cnt_r - CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rom_start_s) state_nx = ST_LOAD;
        else             state_nx = ST_IDLE;
      end
      ST_LOAD: begin
        // End of download wins over a byte arriving in the same cycle.
        if (!ioctl_download) state_nx = ST_HOLD;
        else if (rom_wr_s)   state_nx = ST_WRITE;
        else                 state_nx = ST_LOAD;
      end
      ST_WRITE: begin
        // The pending write always completes; a download that ended meanwhile
        // goes straight to HOLD once it does.
        if (mem_ack) state_nx = ioctl_download ? ST_LOAD : ST_HOLD;
        else         state_nx = ST_WRITE;
      end
      ST_HOLD: begin
        if (rom_start_s)                   state_nx = ST_LOAD;
        else if (hold_cnt_r == CNT_W'(0))  state_nx = ST_RUN;
        else                               state_nx = ST_HOLD;
      end
      ST_RUN: begin
        if (rom_start_s) state_nx = ST_LOAD;
        else             state_nx = ST_RUN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode: values the output registers take at the coming edge.
  always_comb begin
    req_nx_s     = (state_nx == ST_WRITE);
    // game_reset follows soft_reset only in RUN, so it drops on the same
    // edge that leaves HOLD.
    reset_nx_s   = (state_nx == ST_RUN) ? soft_reset : 1'b1;
    latch_s      = (state_r == ST_LOAD) && (state_nx == ST_WRITE);
    hold_load_s  = (state_nx == ST_HOLD) && (state_r != ST_HOLD);
    loaded_set_s = (state_r == ST_HOLD) && (state_nx == ST_RUN);
    ack_take_s   = (state_r == ST_WRITE) && mem_ack;
    ovf_set_s    = (state_r == ST_WRITE) && ioctl_wr;
    sum_clr_s    = (state_nx == ST_LOAD) &&
                   ((state_r == ST_IDLE) || (state_r == ST_HOLD) || (state_r == ST_RUN));
  end

  // Registered ROM port, handshake and status outputs.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      ioctl_wait <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_data   <= 8'd0;
      game_reset <= 1'b1;
      rom_loaded <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      mem_req    <= req_nx_s;
      ioctl_wait <= req_nx_s;
      game_reset <= reset_nx_s;
      if (latch_s) begin
        mem_addr <= ioctl_addr[ADDR_W-1:0];
        mem_data <= ioctl_dout;
      end else begin
        mem_addr <= mem_addr;
        mem_data <= mem_data;
      end
      rom_loaded <= rom_loaded | loaded_set_s;
      ovf_err    <= ovf_err | ovf_set_s;
    end
  end

  // DIP bank and variant flag; written in any state without handshake.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dip_sw   <= 64'd0;
      mod_flag <= 1'b0;
    end else begin
      if (ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr[24:3] == 22'd0)) begin
        dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end else begin
        dip_sw <= dip_sw;
      end
      if (ioctl_wr && (ioctl_index == 8'(MOD_INDEX))) begin
        mod_flag <= (ioctl_dout != 8'd0);
      end else begin
        mod_flag <= mod_flag;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  // Running sum of acknowledged ROM bytes, restarted with each ROM session.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rom_sum <= 16'd0;
    end else if (sum_clr_s) begin
      rom_sum <= 16'd0;
    end else if (ack_take_s) begin
      rom_sum <= rom_sum + {8'd0, mem_data};
    end else begin
      rom_sum <= rom_sum;
    end
  end
`else
  logic unused_s;
  assign unused_s = sum_clr_s ^ ack_take_s;
`endif

endmodule

// File: tb/tb_ioctl_load_ctrl.sv
module tb_ioctl_load_ctrl;

  localparam int ADDR_W    = 17;
  localparam int ROM_BYTES = 98304;
  localparam int HOLD      = 16;
  localparam int DIP_IDX   = 254;
  localparam int MOD_IDX   = 1;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              soft_reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;
  logic [63:0]       dip_sw;
  logic              mod_flag;
  logic              game_reset;
  logic              rom_loaded;
  logic              ovf_err;
`ifdef LOAD_CHECKSUM_EN
  logic [15:0]       rom_sum;
`endif

  ioctl_load_ctrl #(
    .ADDR_W(ADDR_W), .ROM_BYTES(ROM_BYTES), .HOLD_CYCLES(HOLD),
    .DIP_INDEX(DIP_IDX), .MOD_INDEX(MOD_IDX)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .soft_reset(soft_reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .dip_sw(dip_sw),
    .mod_flag(mod_flag), .game_reset(game_reset), .rom_loaded(rom_loaded),
    .ovf_err(ovf_err)
`ifdef LOAD_CHECKSUM_EN
    , .rom_sum(rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [24:0] exp_q[$];        // {addr[16:0], data} of writes still to be accepted
  logic [7:0]  dip_m [8];
  logic        mod_m;
  logic        loaded_m;
  logic        ovf_m;
  logic [15:0] sum_m;
  int          n_exp;
  int          n_acked;

  // Memory responder state.
  int  ack_lat;
  int  lat_cnt;
  bit  ack_drv;
  bit  req_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] dip_pack();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = dip_m[i];
    return r;
  endfunction

  // One clock; afterwards the ROM-side responder checks and answers requests.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (ack_drv) begin
      ack_drv  = 1'b0;
      mem_ack  = 1'b0;
      req_seen = 1'b0;
      n_acked++;
      chk("req_drop", {mem_req, ioctl_wait}, 2'b00);
      if (exp_q.size() > 0) begin
        sum_m = sum_m + {8'd0, exp_q[0][7:0]};
        void'(exp_q.pop_front());
      end
    end else if (mem_req) begin
      if (exp_q.size() == 0) begin
        chk("spurious_req", mem_req, 1'b0);
      end else begin
        chk("mem_addr", mem_addr, exp_q[0][24:8]);
        chk("mem_data", mem_data, exp_q[0][7:0]);
        chk("wait_hi", ioctl_wait, 1'b1);
      end
      if (!req_seen) begin
        req_seen = 1'b1;
        lat_cnt  = ack_lat;
      end
      if (lat_cnt == 0) begin
        ack_drv = 1'b1;
        mem_ack = 1'b1;
      end else begin
        lat_cnt--;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && ioctl_wait; k++) tick();
    chk("wait_timeout", ioctl_wait, 1'b0);
  endtask

  task automatic send_rom(input logic [24:0] a, input logic [7:0] d, input bit wait_done);
    bit inr;
    inr = (a < 25'(ROM_BYTES));
    ioctl_index = 8'd0;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (inr) begin
      exp_q.push_back({a[16:0], d});
      n_exp++;
    end
    tick();
    ioctl_wr = 1'b0;
    if (inr) begin
      chk("req_rise", {mem_req, ioctl_wait}, 2'b11);
      if (wait_done) wait_idle();
    end else begin
      chk("drop_noreq", {mem_req, ioctl_wait}, 2'b00);
    end
  endtask

  task automatic start_download();
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    sum_m          = 16'd0;
    tick();
    chk("dl_reset", game_reset, 1'b1);
    chk("loaded_keep", rom_loaded, loaded_m);
    tick();
  endtask

  // Drop download; game_reset must stay high HOLD cycles after HOLD entry.
  task automatic end_download();
    soft_reset     = 1'b0;
    ioctl_download = 1'b0;
    tick();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    chk("ack_timeout", exp_q.size(), 0);
    chk("all_acked", n_acked, n_exp);
    for (int i = 1; i <= HOLD; i++) begin
      tick();
      chk("hold_reset", game_reset, (i < HOLD));
      chk("hold_loaded", rom_loaded, loaded_m | (i == HOLD));
    end
    loaded_m = 1'b1;
`ifdef LOAD_CHECKSUM_EN
    chk("rom_sum", rom_sum, sum_m);
`endif
  endtask

  task automatic cfg_wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
    if (idx == 8'(DIP_IDX) && a < 25'd8) dip_m[a[2:0]] = d;
    if (idx == 8'(MOD_IDX)) mod_m = (d != 8'd0);
    chk("dip_sw", dip_sw, dip_pack());
    chk("mod_flag", mod_flag, mod_m);
  endtask

  task automatic soft_run(input int n);
    bit s;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      soft_reset = s;
      tick();
      chk("soft_reset", game_reset, s);
    end
    soft_reset = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) dip_m[i] = 8'd0;
    mod_m = 1'b0; loaded_m = 1'b0; ovf_m = 1'b0; sum_m = 16'd0;
    ack_drv = 1'b0; req_seen = 1'b0; mem_ack = 1'b0;
    n_exp = 0; n_acked = 0;
  endtask

  task automatic chk_reset_state();
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 17'd0);
    chk("rst_data", mem_data, 8'd0);
    chk("rst_dip", dip_sw, dip_pack());
    chk("rst_mod", mod_flag, mod_m);
    chk("rst_game_reset", game_reset, 1'b1);
    chk("rst_loaded", rom_loaded, loaded_m);
    chk("rst_ovf", ovf_err, ovf_m);
`ifdef LOAD_CHECKSUM_EN
    chk("rst_sum", rom_sum, 16'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [24:0] a;
    reset_n = 1'b0; soft_reset = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0; mem_ack = 1'b0;
    ack_lat = 0; lat_cnt = 0;
    model_reset();
    repeat (3) tick();
    chk_reset_state();
    reset_n = 1'b1;
    tick();
    chk("idle_game_reset", game_reset, 1'b1);

    // Two bytes, ack three cycles after request.
    ack_lat = 3;
    start_download();
    send_rom(25'd0, 8'h11, 1'b1);
    send_rom(25'd1, 8'h22, 1'b1);
    chk("two_reqs", n_acked, 2);
    // ROM window boundary: first out-of-range address and others dropped.
    send_rom(25'h18000, 8'h5A, 1'b1);
    send_rom(25'h17FFF, 8'h33, 1'b1);
    send_rom(25'h1FFFF, 8'h44, 1'b1);
    chk("boundary_reqs", n_acked, 3);
`ifdef LOAD_CHECKSUM_EN
    chk("sum_drop", rom_sum, 16'h0066);
`endif
    // Byte arriving while a write is pending.
    ack_lat = 4;
    ioctl_index = 8'd0; ioctl_addr = 25'd2; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    exp_q.push_back({17'd2, 8'h77}); n_exp++;
    tick();
    ioctl_addr = 25'd3; ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    ovf_m = 1'b1;
    chk("ovf_set", ovf_err, ovf_m);
    wait_idle();
    chk("ovf_sticky", ovf_err, ovf_m);
    end_download();
    soft_run(6);

    // DIP bank and variant flag.
    cfg_wr(8'(DIP_IDX), 25'd2, 8'hA5);
    chk("dip_byte2", dip_sw[23:16], 8'hA5);
    cfg_wr(8'(DIP_IDX), 25'd8, 8'h55);
    cfg_wr(8'(MOD_IDX), 25'd0, 8'h01);
    chk("mod_set", mod_flag, 1'b1);
    cfg_wr(8'(MOD_IDX), 25'd0, 8'h00);

    // Randomized sessions starting from RUN.
    for (int rep = 0; rep < 5; rep++) begin
      cfg_wr(8'(DIP_IDX), 25'($urandom_range(0, 11)), 8'($urandom));
      cfg_wr(8'(MOD_IDX), 25'd0, 8'($urandom_range(0, 3)));
      ack_lat = $urandom_range(0, 4);
      start_download();
      nb = $urandom_range(2, 6);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) a = 25'(ROM_BYTES - 2 + $urandom_range(0, 4));
        else                           a = 25'($urandom_range(0, ROM_BYTES - 1));
        send_rom(a, 8'($urandom), !((i == nb - 1) && (rep[0] == 1'b1)));
        repeat ($urandom_range(0, 2)) tick();
      end
      end_download();
      soft_run(4);
    end

    // Reset while a write is pending.
    ack_lat = 10;
    start_download();
    send_rom(25'd5, 8'h12, 1'b0);
    tick();
    chk("pre_reset_req", mem_req, 1'b1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    tick();
    model_reset();
    chk_reset_state();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("stray_ack", {mem_req, ioctl_wait}, 2'b00);

    // Checksum wrap-around pattern.
    ack_lat = 1;
    start_download();
    send_rom(25'd0, 8'hFF, 1'b1);
    send_rom(25'd1, 8'h02, 1'b1);
`ifdef LOAD_CHECKSUM_EN
    chk("sum_0101", rom_sum, 16'h0101);
`endif
    end_download();
    chk("ovf_clear", ovf_err, ovf_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
